// File: rtl/cache_control_p.sv
// -----------------------------------------------------------------------------
// cache_control_p
// Control FSM for the 2-way pipelined L1 cache datapath (cache_datapath_p).
// Hits are serviced one per cycle with no bubbles. A miss freezes the CPU
// pipeline and is serialised as writeback (dirty victim only), fetch, install
// and replay. The replay re-presents the held request so that it hits and
// completes like a normal hit. Also keeps saturating hit/miss/writeback
// performance counters.
//
// State table
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   IDLE       | accept CPU requests; hits complete same cycle, misses latch
//   WRITEBACK  | dirty victim line written to memory through the adaptor
//   FETCH      | requested line read from memory through the adaptor
//   INSTALL    | memory line written into the victim way, marked clean
//   REPLAY     | held request re-run as a hit; mem_resp pulsed
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mem_read, mem_write           CPU request (mutually exclusive)
//   mem_resp, stall               CPU completion and pipeline freeze
//   cache_hit, hit1               datapath hit and hit way
//   dirty_o, lru_out              datapath victim dirty bit and LRU way
//   source_sel, way_sel, tag_sel  datapath data/way/tag selects
//   addrmux_sel                   0 live CPU address, 1 held address
//   load_cache, load_dirty,       array, dirty and LRU write strobes
//   dirty_sel, load_lru
//   read_lru, read_cache_data     array read enables, always on
//   pmem_read, pmem_write,        cacheline adaptor handshake
//   pmem_resp
//   hit_cnt, miss_cnt, wb_cnt     saturating performance counters
// -----------------------------------------------------------------------------
module cache_control_p #(
    parameter int unsigned CTR_W = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             stall,

    input  logic             cache_hit,
    input  logic             hit1,
    input  logic             dirty_o,
    input  logic             lru_out,

    output logic             source_sel,
    output logic             way_sel,
    output logic             tag_sel,
    output logic             addrmux_sel,
    output logic             load_cache,
    output logic             load_dirty,
    output logic             dirty_sel,
    output logic             load_lru,
    output logic             read_lru,
    output logic             read_cache_data,

    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,

    output logic [CTR_W-1:0] hit_cnt,
    output logic [CTR_W-1:0] miss_cnt,
    output logic [CTR_W-1:0] wb_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_FETCH,
        ST_INSTALL,
        ST_REPLAY
    } state_e;

    localparam logic [CTR_W-1:0] CNT_ONE = CTR_W'(1);
    localparam logic [CTR_W-1:0] CNT_MAX = {CTR_W{1'b1}};

    state_e           state_q, state_d;
    logic             victim_q, victim_d;
    logic             write_q, write_d;
    logic [CTR_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic             hit_inc, miss_inc, wb_inc;
    logic             req;

    assign req = mem_read | mem_write;

    always_comb begin
        state_d         = state_q;
        victim_d        = victim_q;
        write_d         = write_q;
        mem_resp        = 1'b0;
        stall           = 1'b0;
        source_sel      = 1'b0;
        way_sel         = 1'b0;
        tag_sel         = 1'b0;
        addrmux_sel     = 1'b0;
        load_cache      = 1'b0;
        load_dirty      = 1'b0;
        dirty_sel       = 1'b0;
        load_lru        = 1'b0;
        read_lru        = 1'b1;
        read_cache_data = 1'b1;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;
        wb_inc          = 1'b0;

        // While reset is asserted every strobe stays quiet so an aborted miss
        // can never write the arrays or keep the adaptor busy.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (cache_hit) begin
                            mem_resp = 1'b1;
                            way_sel  = hit1;
                            load_lru = 1'b1;
                            hit_inc  = 1'b1;
                            if (mem_write) begin
                                load_cache = 1'b1;
                                load_dirty = 1'b1;
                                dirty_sel  = 1'b1;
                            end
                        end else begin
                            stall    = 1'b1;
                            miss_inc = 1'b1;
                            victim_d = lru_out;
                            // Request type is held so the replay completes the
                            // access even if the CPU drops its request.
                            write_d  = mem_write;
                            state_d  = dirty_o ? ST_WRITEBACK : ST_FETCH;
                        end
                    end
                end

                ST_WRITEBACK: begin
                    addrmux_sel = 1'b1;
                    way_sel     = victim_q;
                    pmem_write  = 1'b1;
                    stall       = 1'b1;
                    if (pmem_resp) begin
                        wb_inc  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    addrmux_sel = 1'b1;
                    tag_sel     = 1'b1;
                    pmem_read   = 1'b1;
                    stall       = 1'b1;
                    if (pmem_resp) begin
                        state_d = ST_INSTALL;
                    end
                end

                ST_INSTALL: begin
                    source_sel = 1'b1;
                    way_sel    = victim_q;
                    load_cache = 1'b1;
                    load_dirty = 1'b1;
                    stall      = 1'b1;
                    state_d    = ST_REPLAY;
                end

                ST_REPLAY: begin
                    addrmux_sel = 1'b1;
                    stall       = 1'b1;
                    mem_resp    = 1'b1;
                    way_sel     = hit1;
                    load_lru    = 1'b1;
                    if (write_q) begin
                        load_cache = 1'b1;
                        load_dirty = 1'b1;
                        dirty_sel  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            victim_q   <= 1'b0;
            write_q    <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            write_q  <= write_d;
            if (hit_inc && (hit_cnt_q != CNT_MAX)) begin
                hit_cnt_q <= hit_cnt_q + CNT_ONE;
            end
            if (miss_inc && (miss_cnt_q != CNT_MAX)) begin
                miss_cnt_q <= miss_cnt_q + CNT_ONE;
            end
            if (wb_inc && (wb_cnt_q != CNT_MAX)) begin
                wb_cnt_q <= wb_cnt_q + CNT_ONE;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;

`ifndef SYNTHESIS
    // The line was just installed, so the replayed access cannot miss.
    replay_must_hit: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_REPLAY) |-> cache_hit)
        else $fatal(1, "cache_control_p: replay missed");

    pmem_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(pmem_read && pmem_write))
        else $fatal(1, "cache_control_p: pmem_read and pmem_write both high");
`endif

endmodule

// File: tb/tb_cache_control_p.sv
module tb_cache_control_p;

    logic clk;
    logic rst;
    logic mem_read, mem_write;
    logic cache_hit, hit1, dirty_o, lru_out, pmem_resp;

    logic mem_resp, stall, source_sel, way_sel, tag_sel, addrmux_sel;
    logic load_cache, load_dirty, dirty_sel, load_lru, read_lru, read_cache_data;
    logic pmem_read, pmem_write;
    logic [31:0] hit_cnt, miss_cnt, wb_cnt;

    logic mem_resp4, stall4, source_sel4, way_sel4, tag_sel4, addrmux_sel4;
    logic load_cache4, load_dirty4, dirty_sel4, load_lru4, read_lru4, read_cache_data4;
    logic pmem_read4, pmem_write4;
    logic [3:0] hit_cnt4, miss_cnt4, wb_cnt4;

    int checks = 0;
    int errors = 0;

    cache_control_p #(.CTR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .stall(stall),
        .cache_hit(cache_hit), .hit1(hit1), .dirty_o(dirty_o), .lru_out(lru_out),
        .source_sel(source_sel), .way_sel(way_sel), .tag_sel(tag_sel),
        .addrmux_sel(addrmux_sel), .load_cache(load_cache), .load_dirty(load_dirty),
        .dirty_sel(dirty_sel), .load_lru(load_lru), .read_lru(read_lru),
        .read_cache_data(read_cache_data),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    cache_control_p #(.CTR_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp4), .stall(stall4),
        .cache_hit(cache_hit), .hit1(hit1), .dirty_o(dirty_o), .lru_out(lru_out),
        .source_sel(source_sel4), .way_sel(way_sel4), .tag_sel(tag_sel4),
        .addrmux_sel(addrmux_sel4), .load_cache(load_cache4), .load_dirty(load_dirty4),
        .dirty_sel(dirty_sel4), .load_lru(load_lru4), .read_lru(read_lru4),
        .read_cache_data(read_cache_data4),
        .pmem_read(pmem_read4), .pmem_write(pmem_write4), .pmem_resp(pmem_resp),
        .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4), .wb_cnt(wb_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_read = 1'b0; mem_write = 1'b0; cache_hit = 1'b0; hit1 = 1'b0;
        dirty_o = 1'b0; lru_out = 1'b0; pmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] outs;
        idle_inputs();
        rst = 1'b1;
        cyc(); cyc(); #1;
        outs = {mem_resp, stall, source_sel, way_sel, tag_sel, addrmux_sel, load_cache,
                load_dirty, dirty_sel, load_lru, read_lru, read_cache_data,
                pmem_read, pmem_write, 2'b00};
        checks++;
        if (outs !== 16'h0030) begin
            errors++; $display("FAIL reset_outputs got %h exp 0030", outs);
        end
        cyc(); rst = 1'b0; #1;
        checks++;
        if ({hit_cnt, miss_cnt, wb_cnt} !== 96'd0) begin
            errors++; $display("FAIL reset_counters got %0d %0d %0d exp 0 0 0", hit_cnt, miss_cnt, wb_cnt);
        end
        cyc(); #1;
        checks++;
        if ({stall, pmem_read, pmem_write, read_lru, read_cache_data} !== 5'b00011) begin
            errors++; $display("FAIL reset_idle got %b exp 00011", {stall, pmem_read, pmem_write, read_lru, read_cache_data});
        end
    endtask

    task automatic test_read_hit();
        cyc(); mem_read = 1'b1; cache_hit = 1'b1; hit1 = 1'b1; #1;
        checks++;
        if ({mem_resp, way_sel, load_lru, load_cache, stall} !== 5'b11100) begin
            errors++; $display("FAIL read_hit_strobes got %b exp 11100", {mem_resp, way_sel, load_lru, load_cache, stall});
        end
        cyc(); idle_inputs(); #1;
        checks++;
        if (hit_cnt !== 32'd1) begin
            errors++; $display("FAIL read_hit_cnt got %0d exp 1", hit_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int resp_n = 0;
        cyc(); mem_write = 1'b1; cache_hit = 1'b1; hit1 = 1'b0; #1;
        checks++;
        if ({load_cache, load_dirty, dirty_sel, source_sel, way_sel, mem_resp} !== 6'b111001) begin
            errors++; $display("FAIL write_hit_strobes got %b exp 111001",
                               {load_cache, load_dirty, dirty_sel, source_sel, way_sel, mem_resp});
        end
        if (mem_resp) resp_n++;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            if (mem_resp && !stall) resp_n++;
        end
        cyc(); idle_inputs(); #1;
        checks++;
        if (resp_n !== 4) begin
            errors++; $display("FAIL b2b_resp_count got %0d exp 4", resp_n);
        end
        checks++;
        if (hit_cnt !== 32'd5) begin
            errors++; $display("FAIL b2b_hit_cnt got %0d exp 5", hit_cnt);
        end
    endtask

    task automatic test_clean_miss();
        int rd_n = 0, inst_k = -1, inst_way = -1, resp_k = -1, bad = 0;
        cyc(); mem_read = 1'b1; cache_hit = 1'b0; lru_out = 1'b1; dirty_o = 1'b0; #1;
        checks++;
        if ({stall, mem_resp, pmem_read} !== 3'b100) begin
            errors++; $display("FAIL clean_miss_detect got %b exp 100", {stall, mem_resp, pmem_read});
        end
        for (int k = 1; k <= 20 && resp_k < 0; k++) begin
            cyc();
            mem_read = 1'b0; lru_out = 1'b0; hit1 = 1'b1;
            pmem_resp = (k == 5); cache_hit = (k >= 7);
            #1;
            if (pmem_read) begin
                rd_n++;
                if (!tag_sel || !addrmux_sel || !stall || pmem_write) bad++;
            end
            if (load_cache && source_sel) begin inst_k = k; inst_way = int'(way_sel); end
            if (mem_resp) resp_k = k;
        end
        pmem_resp = 1'b0;
        checks++;
        if (rd_n !== 5 || bad !== 0) begin
            errors++; $display("FAIL clean_fetch got %0d cycles %0d bad exp 5 cycles 0 bad", rd_n, bad);
        end
        checks++;
        if (inst_k !== 6 || inst_way !== 1) begin
            errors++; $display("FAIL clean_install got cycle %0d way %0d exp cycle 6 way 1", inst_k, inst_way);
        end
        checks++;
        if (resp_k !== 7) begin
            errors++; $display("FAIL clean_resp_cycle got %0d exp 7", resp_k);
        end
        cyc(); idle_inputs(); #1;
        checks++;
        if (stall !== 1'b0 || miss_cnt !== 32'd1 || wb_cnt !== 32'd0 || hit_cnt !== 32'd5) begin
            errors++; $display("FAIL clean_after got stall %b miss %0d wb %0d hit %0d exp 0 1 0 5",
                               stall, miss_cnt, wb_cnt, hit_cnt);
        end
    endtask

    task automatic test_dirty_miss();
        int wr_n = 0, rd_n = 0, bad = 0, inst_k = -1, resp_k = -1;
        logic [2:0] inst_v = 3'b111;
        logic [1:0] resp_v = 2'b00;
        cyc(); mem_write = 1'b1; cache_hit = 1'b0; lru_out = 1'b0; dirty_o = 1'b1; #1;
        checks++;
        if ({stall, mem_resp, pmem_write} !== 3'b100) begin
            errors++; $display("FAIL dirty_miss_detect got %b exp 100", {stall, mem_resp, pmem_write});
        end
        for (int k = 1; k <= 25 && resp_k < 0; k++) begin
            cyc();
            lru_out = 1'b1; dirty_o = 1'b0; hit1 = 1'b0;
            pmem_resp = (k == 3 || k == 6); cache_hit = (k >= 8);
            #1;
            if (pmem_write) begin
                wr_n++;
                if (tag_sel !== 1'b0 || way_sel !== 1'b0 || pmem_read || !addrmux_sel) bad++;
            end
            if (pmem_read) begin
                rd_n++;
                if (tag_sel !== 1'b1) bad++;
            end
            if (load_cache && source_sel) begin
                inst_k = k; inst_v = {way_sel, dirty_sel, load_dirty};
            end
            if (mem_resp) begin resp_k = k; resp_v = {load_cache, dirty_sel}; end
        end
        pmem_resp = 1'b0;
        checks++;
        if (wr_n !== 3 || rd_n !== 3 || bad !== 0) begin
            errors++; $display("FAIL dirty_pmem got wr %0d rd %0d bad %0d exp 3 3 0", wr_n, rd_n, bad);
        end
        checks++;
        if (inst_k !== 7 || inst_v !== 3'b001) begin
            errors++; $display("FAIL dirty_install got cycle %0d way/dsel/ldirty %b exp 7 001", inst_k, inst_v);
        end
        checks++;
        if (resp_k !== 8 || resp_v !== 2'b11) begin
            errors++; $display("FAIL dirty_replay got cycle %0d load/dsel %b exp 8 11", resp_k, resp_v);
        end
        cyc(); idle_inputs(); pmem_resp = 1'b1; #1;
        checks++;
        if ({stall, pmem_read, pmem_write} !== 3'b000 || wb_cnt !== 32'd1 || miss_cnt !== 32'd2) begin
            errors++; $display("FAIL dirty_after got spp %b wb %0d miss %0d exp 000 1 2",
                               {stall, pmem_read, pmem_write}, wb_cnt, miss_cnt);
        end
        cyc(); pmem_resp = 1'b0; #1;
        checks++;
        if (wb_cnt !== 32'd1 || load_cache !== 1'b0 || hit_cnt !== 32'd5) begin
            errors++; $display("FAIL stray_resp got wb %0d load %b hit %0d exp 1 0 5", wb_cnt, load_cache, hit_cnt);
        end
    endtask

    task automatic test_reset_mid_miss();
        cyc(); mem_read = 1'b1; cache_hit = 1'b0; lru_out = 1'b1; dirty_o = 1'b0; #1;
        cyc(); mem_read = 1'b0; #1;
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++; $display("FAIL midrst_in_fetch got %b exp 1", pmem_read);
        end
        cyc(); rst = 1'b1; #1;
        checks++;
        if (load_cache !== 1'b0) begin
            errors++; $display("FAIL midrst_load_during got %b exp 0", load_cache);
        end
        cyc(); rst = 1'b0; #1;
        checks++;
        if ({pmem_read, stall, load_cache} !== 3'b000 || {hit_cnt, miss_cnt, wb_cnt} !== 96'd0) begin
            errors++; $display("FAIL midrst_after got %b cnt %0d %0d %0d exp 000 0 0 0",
                               {pmem_read, stall, load_cache}, hit_cnt, miss_cnt, wb_cnt);
        end
        cyc(); pmem_resp = 1'b1; #1;
        cyc(); pmem_resp = 1'b0; #1;
        checks++;
        if ({load_cache, pmem_read, stall, mem_resp} !== 4'b0000) begin
            errors++; $display("FAIL midrst_no_install got %b exp 0000", {load_cache, pmem_read, stall, mem_resp});
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            cyc(); mem_read = 1'b1; cache_hit = 1'b1; hit1 = 1'b0;
        end
        cyc(); idle_inputs(); #1;
        checks++;
        if (hit_cnt4 !== 4'd15) begin
            errors++; $display("FAIL sat_hit_cnt4 got %0d exp 15", hit_cnt4);
        end
        checks++;
        if (hit_cnt !== 32'd20) begin
            errors++; $display("FAIL sat_hit_cnt32 got %0d exp 20", hit_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_read_hit();
        test_back_to_back();
        test_clean_miss();
        test_dirty_miss();
        test_reset_mid_miss();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
